// File: rtl/hs_arb_pkg.sv
// rtl/hs_arb_pkg.sv - shared types and defaults for the hiscore dump RAM port arbiter
package hs_arb_pkg;

  localparam int AW_DEF       = 6;
  localparam int PAUSEPAD_DEF = 2;
  localparam int TIMEOUT_DEF  = 4096;

  typedef enum logic [2:0] {
    IDLE,
    PAUSE,
    SETTLE,
    GRANT,
    RELEASE
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_DL,
    OWN_UL,
    OWN_SC
  } owner_e;

  // One-hot {dl, ul, sc} view of an owner
  function automatic logic [2:0] owner_bits(input owner_e o);
    return {o == OWN_DL, o == OWN_UL, o == OWN_SC};
  endfunction

endpackage

// File: rtl/hs_arb_prio.sv
// rtl/hs_arb_prio.sv - fixed-priority requester encoder (dl > ul > sc)
module hs_arb_prio
  import hs_arb_pkg::*;
(
  input  logic   dl_req,
  input  logic   ul_req,
  input  logic   sc_req,
  output owner_e owner
);

  always_comb begin
    owner = OWN_NONE;
    if (dl_req) begin
      owner = OWN_DL;
    end else if (ul_req) begin
      owner = OWN_UL;
    end else if (sc_req) begin
      owner = OWN_SC;
    end
  end

endmodule

// File: rtl/hs_port_arbiter.sv
// rtl/hs_port_arbiter.sv - shares the hiscore dump RAM port behind the CPU pause handshake
// Optional grant watchdog enabled by defining HS_ARB_TIMEOUT_EN.
module hs_port_arbiter
  import hs_arb_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int PAUSEPAD = PAUSEPAD_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          paused_i,
  output logic          pause_req_o,
  input  logic          dl_req,
  input  logic [AW-1:0] dl_addr,
  input  logic [7:0]    dl_data,
  input  logic          dl_wr,
  output logic          dl_gnt,
  input  logic          ul_req,
  input  logic [AW-1:0] ul_addr,
  input  logic          ul_rd,
  output logic          ul_gnt,
  output logic          ul_valid,
  input  logic          sc_req,
  input  logic [AW-1:0] sc_addr,
  input  logic          sc_rd,
  output logic          sc_gnt,
  output logic          sc_valid,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [7:0]    ram_wdata,
  output logic          busy_o
);

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d, winner;
  logic [3:0]    cnt_q, cnt_d;
  logic          held_q, held_d;
  logic          pause_q, pause_d;
  logic [2:0]    gnt_q, gnt_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [1:0]    rd_q, rd_d;
  logic [1:0]    valid_q, valid_d;
  logic          busy_q, busy_d;

  logic [2:0]    req_vec, arb_req;
  logic          owner_req, owner_stb, io_ok, timeout_hit, gnt_on;
  logic [AW-1:0] owner_addr;

  assign req_vec = {dl_req, ul_req, sc_req};

  always_comb begin
    owner_req  = 1'b0;
    owner_stb  = 1'b0;
    owner_addr = '0;
    case (owner_q)
      OWN_DL: begin owner_req = dl_req; owner_stb = dl_wr; owner_addr = dl_addr; end
      OWN_UL: begin owner_req = ul_req; owner_stb = ul_rd; owner_addr = ul_addr; end
      OWN_SC: begin owner_req = sc_req; owner_stb = sc_rd; owner_addr = sc_addr; end
      default: ;
    endcase
  end

  // Strobes reach the RAM only while granted and the CPU is really halted
  assign io_ok = (state_q == GRANT) && paused_i;

`ifdef HS_ARB_TIMEOUT_EN
  logic [15:0] wd_q, wd_d;
  logic [2:0]  mask_q, mask_d;

  assign timeout_hit = (state_q == GRANT) && !(io_ok && owner_stb) &&
                       (wd_q == 16'(TIMEOUT - 1));
  assign arb_req     = req_vec & ~mask_q;

  // A timed-out owner stays masked until it lets go of its request
  always_comb begin
    wd_d   = '0;
    mask_d = mask_q & req_vec;
    if (state_q == GRANT) begin
      wd_d = (io_ok && owner_stb) ? 16'd0 : wd_q + 16'd1;
    end
    if (timeout_hit) begin
      mask_d = mask_d | owner_bits(owner_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_q   <= '0;
      mask_q <= '0;
    end else begin
      wd_q   <= wd_d;
      mask_q <= mask_d;
    end
  end
`else
  logic [15:0] unused_timeout;

  assign unused_timeout = 16'(TIMEOUT);
  assign timeout_hit    = 1'b0;
  assign arb_req        = req_vec;
`endif

  hs_arb_prio u_prio (
    .dl_req (arb_req[2]),
    .ul_req (arb_req[1]),
    .sc_req (arb_req[0]),
    .owner  (winner)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    held_d  = held_q;
    case (state_q)
      IDLE: begin
        if (winner != OWN_NONE) begin
          owner_d = winner;
          state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (!owner_req) begin
          state_d = RELEASE;
        end else if (paused_i) begin
          cnt_d   = '0;
          state_d = (PAUSEPAD == 0) ? GRANT : SETTLE;
        end
      end
      SETTLE: begin
        if (!owner_req) begin
          state_d = RELEASE;
        end else if (!paused_i) begin
          state_d = PAUSE;
        end else if (cnt_q == 4'(PAUSEPAD - 1)) begin
          state_d = GRANT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      GRANT: begin
        held_d = 1'b1;
        if (!owner_req || timeout_hit) begin
          state_d = RELEASE;
        end else if (!paused_i) begin
          state_d = PAUSE;
        end
      end
      RELEASE: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
        held_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it
  always_comb begin
    gnt_on  = (state_d == GRANT) ||
              (held_d && ((state_d == PAUSE) || (state_d == SETTLE)));
    pause_d = (state_d == PAUSE) || (state_d == SETTLE) || (state_d == GRANT);
    busy_d  = (state_d != IDLE);
    gnt_d   = gnt_on ? owner_bits(owner_d) : 3'b000;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (io_ok) begin
      addr_d = owner_addr;
      if (owner_q == OWN_DL) begin
        wdata_d = dl_data;
      end
    end
    we_d    = io_ok && (owner_q == OWN_DL) && dl_wr;
    rd_d    = {io_ok && (owner_q == OWN_UL) && ul_rd,
               io_ok && (owner_q == OWN_SC) && sc_rd};
    valid_d = rd_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= OWN_NONE;
      cnt_q   <= '0;
      held_q  <= 1'b0;
      pause_q <= 1'b0;
      gnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      valid_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      held_q  <= held_d;
      pause_q <= pause_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign pause_req_o = pause_q;
  assign dl_gnt      = gnt_q[2];
  assign ul_gnt      = gnt_q[1];
  assign sc_gnt      = gnt_q[0];
  assign ram_we      = we_q;
  assign ram_addr    = addr_q;
  assign ram_wdata   = wdata_q;
  assign ul_valid    = valid_q[1];
  assign sc_valid    = valid_q[0];
  assign busy_o      = busy_q;

endmodule

// File: doc/hs_port_arbiter.md
Name: hs_port_arbiter

Overview:
- Sequences and shares the single hiscore dump RAM port (64 bytes, 1-cycle read latency) between three requesters:
  - HPS download writes (nvram restore).
  - HPS upload reads (nvram save).
  - The autosave change scanner.
- Owns the CPU pause handshake: no requester touches the port until the CPU is confirmed paused and a settle delay has elapsed.
- Sits between hps_io/nvram logic and the game core's hs_address/hs_data/hs_write port.

Parameters:
- AW, 6, RAM address width (dump size 2^AW bytes).
- PAUSEPAD, 2, settle cycles after paused_i rises before grant (0..15).
- TIMEOUT, 4096, watchdog cycles per grant; used only with HS_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- paused_i  in  1  CPU is halted (from pause block).
- pause_req_o  out  1  request CPU halt.
- dl_req  in  1  download requester wants the port (level, held for the whole transfer).
- dl_addr  in  AW  download address.
- dl_data  in  8  download write data.
- dl_wr  in  1  download write strobe.
- dl_gnt  out  1  download owns the port.
- ul_req  in  1  upload requester wants the port.
- ul_addr  in  AW  upload address.
- ul_rd  in  1  upload read strobe.
- ul_gnt  out  1  upload owns the port.
- ul_valid  out  1  ram_rdata valid for upload.
- sc_req  in  1  scanner wants the port.
- sc_addr  in  AW  scanner address.
- sc_rd  in  1  scanner read strobe.
- sc_gnt  out  1  scanner owns the port.
- sc_valid  out  1  ram_rdata valid for scanner.
- ram_addr  out  AW  to game core hs_address.
- ram_we  out  1  to game core hs_write.
- ram_wdata  out  8  to game core hs_data_in.
- busy_o  out  1  arbiter not IDLE.

Behaviour:
- Reset: state IDLE. All grants 0, pause_req_o 0, ram_we 0, ram_addr 0, ram_wdata 0, valids 0, busy_o 0.
- All outputs are registered.
- States: IDLE, PAUSE, SETTLE, GRANT, RELEASE.
- IDLE: when any req is high, latch the winner and go to PAUSE.
  - Fixed priority: dl > ul > sc.
  - The winner is latched; a higher-priority request arriving later does not pre-empt the current owner.
- PAUSE: pause_req_o=1; wait for paused_i=1, then go to SETTLE.
  - If the winner's req drops before paused_i rises: go to RELEASE.
- SETTLE: count PAUSEPAD cycles, then assert the winner's gnt and go to GRANT.
  - PAUSEPAD=0 means gnt asserts on the cycle after paused_i is seen.
- GRANT: ram_addr/ram_we/ram_wdata follow the owner's inputs, registered (1-cycle latency).
  - Only the owner's strobes pass; non-owner strobes are ignored.
  - ram_we asserts only for dl_wr from the owner.
  - ul_rd/sc_rd pulse in cycle N: ram_addr presented in N+1, owner's valid=1 in N+2, aligned with ram_rdata from the core.
  - Owner deasserts req: gnt drops next cycle, go to RELEASE. A pending read's valid still fires.
- RELEASE: pause_req_o=0 for one cycle, return to IDLE, re-arbitrate.
  - Guarantees one pause-free cycle between owners.
- paused_i falling during GRANT (external unpause): hold gnt, block strobes (ram_we forced 0, reads not issued), return to PAUSE. Resume GRANT after paused_i and SETTLE again.
- Reset mid-transfer: everything to reset values immediately; pause is released.
- busy_o is high in every state except IDLE.

Optional Feature:
- Macro: HS_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter runs while in GRANT and resets on each owner strobe.
  - Reaching TIMEOUT drops gnt and forces RELEASE.
  - The owner is then masked until its req deasserts, so a stuck requester cannot hold the CPU paused indefinitely.
- Undefined: no counter; a grant is held until req drops.

Decomposition:
- Package hs_arb_pkg holds:
  - state enum typedef (IDLE, PAUSE, SETTLE, GRANT, RELEASE).
  - owner enum (OWN_NONE, OWN_DL, OWN_UL, OWN_SC).
  - localparam defaults for AW and PAUSEPAD.
- One natural sub-module: hs_arb_prio, a combinational fixed-priority encoder returning the owner enum from the three reqs.
- FSM, datapath muxing and optional watchdog stay in the top.

Test Plan:
- dl_req=1, paused_i rises 3 cycles after pause_req_o, PAUSEPAD=2 → dl_gnt rises exactly 2 cycles after paused_i is sampled. Then dl_wr with addr 0x05, data 0xA5 → ram_we=1, ram_addr=0x05, ram_wdata=0xA5 one cycle later.
- ul_req and sc_req raised in the same cycle → ul wins. ul_rd at 0x3F → ul_valid two cycles later, sc_valid stays 0. ul_req drops → one RELEASE cycle with pause_req_o=0, then sc is granted after a fresh pause/settle.
- sc owns the port; dl_req rises mid-grant → no pre-emption, dl_gnt stays 0 until sc_req drops. sc_wr-style strobes from dl are ignored (ram_we stays 0).
- Grant held; paused_i drops for 4 cycles while dl_wr toggles → ram_we stays 0 throughout. After paused_i returns plus PAUSEPAD, writes resume.
- reset asserted mid-grant → pause_req_o, gnt and ram_we all 0 asynchronously, state IDLE.
- With HS_ARB_TIMEOUT_EN and TIMEOUT=16: ul_req held, no strobes → ul_gnt drops after 16 cycles; ul is not regranted until ul_req toggles low.
